instr_fetch: RTL and testbench

Instruction fetch stage for the RV32IM core: keeps the PC, issues word reads to instruction memory, and buffers returned words with their PCs in a 3-entry FIFO. It feeds the combinational decoder through a valid/ready handshake and flushes on taken branches and jumps from execute. It sits directly upstream of decode.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 47 ++++
 rtl/instr_fetch.sv | 56 +++++
 tb/tb_instr_fetch.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-stage constants, FIFO entry type and PC alignment helper
package instr_fetch_pkg;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int INSTR_W = 32;
    localparam int FETCH_DEPTH = 3;
    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus bundle
//   imem_req_*  : word read request to instruction memory (valid/ready, addr)
//   imem_rsp_*  : in-order read data from instruction memory
//   redirect_*  : taken branch / jump target from execute
//   out_*       : instruction + PC handshake towards decode
//   master = fetch stage, slave = memory/decode/execute environment
interface instr_fetch_if;
    import instr_fetch_pkg::*;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [31:0]        imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [31:0]        out_pc;
    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: parameterised-depth synchronous FIFO with flush
//   clk, rst : clock, synchronous active-high reset
//   flush_i  : empty the FIFO at the next edge
//   push_i   : write din_i (ignored when full without a pop)
//   pop_i    : drop the head entry (ignored when empty)
//   dout_o   : head entry
//   count_o  : number of stored entries
module fetch_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [W-1:0]                 din_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;
    assign do_pop  = pop_i && cnt_q != '0;
    assign do_push = push_i && (cnt_q != FULL || do_pop);
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
            if (do_pop) rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32 fetch stage - PC, memory request issue, response buffering, redirect flush
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_if.master (imem request/response, redirect, decode handshake)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    logic [31:0]    fetch_pc_q, fetch_pc_d, pcq_head;
    logic [CNT_W-1:0] discard_q, discard_d, data_cnt, pcq_cnt;
    logic [CNT_W:0] inflight, busy;
    logic           run_q, accept, keep;
    fetch_entry_t   head;
    // Every accepted request is either waiting in the pc queue or marked for discard.
    assign inflight = {1'b0, pcq_cnt} + {1'b0, discard_q};
    assign busy     = inflight + {1'b0, data_cnt};
    // run_q holds issue off for the first cycle after reset is released.
    assign bus.imem_req_valid = !rst && run_q && !bus.redirect_valid && busy < (CNT_W+1)'(FETCH_DEPTH);
    assign bus.imem_req_addr  = fetch_pc_q;
    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    assign keep   = bus.imem_rsp_valid && discard_q == '0 && !bus.redirect_valid;
    assign bus.out_valid = data_cnt != '0;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    always_comb begin
        fetch_pc_d = bus.redirect_valid ? word_align(bus.redirect_pc) : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        discard_d  = bus.redirect_valid ? CNT_W'(inflight) - CNT_W'(bus.imem_rsp_valid)
                                        : discard_q - CNT_W'(bus.imem_rsp_valid && discard_q != '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            run_q      <= 1'b1;
        end
    end
    // PCs of live requests, popped as their responses return in order.
    fetch_fifo #(.DEPTH(FETCH_DEPTH), .W(32)) u_pcq (
        .clk(clk), .rst(rst), .flush_i(bus.redirect_valid),
        .push_i(accept), .din_i(fetch_pc_q), .pop_i(keep),
        .dout_o(pcq_head), .count_o(pcq_cnt)
    );
    fetch_fifo #(.DEPTH(FETCH_DEPTH), .W($bits(fetch_entry_t))) u_buf (
        .clk(clk), .rst(rst), .flush_i(bus.redirect_valid),
        .push_i(keep), .din_i({pcq_head, bus.imem_rsp_data}), .pop_i(bus.out_valid && bus.out_ready),
        .dout_o(head), .count_o(data_cnt)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch with an in-order memory model
module tb_instr_fetch;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    logic        clk = 1'b0;
    logic        rst, sel;
    logic        req_ready, rsp_valid, redirect_valid, out_ready;
    logic [31:0] rsp_data, redirect_pc;
    logic        req_valid, out_valid;
    logic [31:0] req_addr, out_pc, out_instr;
    req_t        q[$];
    logic [31:0] got_pc[$];
    int          cyc, last_due, lat_min, lat_max, rr_pct, nrecv;
    int          n_checks, n_fail;
    logic [31:0] exp_pc, prev_pc, prev_instr, s_req_addr;
    bit          prev_stall, s_req_valid;

    always #5 clk = ~clk;

    instr_fetch_if bus0();
    instr_fetch_if bus1();
    assign bus0.imem_req_ready = req_ready;
    assign bus0.imem_rsp_valid = rsp_valid;
    assign bus0.imem_rsp_data  = rsp_data;
    assign bus0.redirect_valid = redirect_valid;
    assign bus0.redirect_pc    = redirect_pc;
    assign bus0.out_ready      = out_ready;
    assign bus1.imem_req_ready = req_ready;
    assign bus1.imem_rsp_valid = rsp_valid;
    assign bus1.imem_rsp_data  = rsp_data;
    assign bus1.redirect_valid = redirect_valid;
    assign bus1.redirect_pc    = redirect_pc;
    assign bus1.out_ready      = out_ready;
    assign req_valid = sel ? bus1.imem_req_valid : bus0.imem_req_valid;
    assign req_addr  = sel ? bus1.imem_req_addr  : bus0.imem_req_addr;
    assign out_valid = sel ? bus1.out_valid      : bus0.out_valid;
    assign out_pc    = sel ? bus1.out_pc         : bus0.out_pc;
    assign out_instr = sel ? bus1.out_instr      : bus0.out_instr;

    instr_fetch u0 (.clk(clk), .rst(rst), .bus(bus0));
    instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // One clock cycle: memory model answers, bench drives, outputs are checked against
    // the program-order model (contiguous PCs from the last reset/redirect target).
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        int due;
        @(negedge clk);
        rsp_valid = q.size() != 0 && q[0].due == cyc;
        rsp_data = rsp_valid ? mem_word(q[0].addr) : $urandom;
        req_ready = $urandom_range(99) < rr_pct;
        out_ready = rdy;
        redirect_valid = redir;
        redirect_pc = rpc;
        #1;
        if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== prev_pc || out_instr !== prev_instr) begin
                n_fail++;
                $display("FAIL hold: valid=%b pc=%h instr=%h required valid=1 pc=%h instr=%h", out_valid, out_pc, out_instr, prev_pc, prev_instr);
            end
        end
        if (req_valid) begin
            n_checks++;
            if (req_addr[1:0] !== 2'b00 || redir) begin
                n_fail++;
                $display("FAIL req: addr=%h during_redirect=%b required aligned and no redirect", req_addr, redir);
            end
        end
        if (out_valid && rdy) begin
            n_checks++;
            if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL out: pc=%h instr=%h required pc=%h instr=%h", out_pc, out_instr, exp_pc, mem_word(exp_pc));
            end
            got_pc.push_back(out_pc);
            exp_pc += 32'd4;
            nrecv++;
        end
        prev_stall = out_valid === 1'b1 && !rdy && !redir;
        prev_pc = out_pc;
        prev_instr = out_instr;
        s_req_valid = req_valid;
        s_req_addr = req_addr;
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        if (rsp_valid) void'(q.pop_front());
        if (req_valid && req_ready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            q.push_back('{addr: req_addr, due: due});
            last_due = due;
        end
        n_checks++;
        if (q.size() > 3) begin
            n_fail++;
            $display("FAIL outstanding: %0d requests in flight, required at most 3", q.size());
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit s);
        @(negedge clk);
        sel = s;
        rst = 1'b1;
        rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        req_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: req_valid=%b out_valid=%b required 0 0", req_valid, out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        got_pc.delete();
        last_due = cyc;
        prev_stall = 1'b0;
        exp_pc = s ? 32'hFFFF_FFF8 : 32'h0;
        #1;
        n_checks++;
        if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: req_valid=%b out_valid=%b required 0 0", req_valid, out_valid);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; rr_pct = 100;
        do_reset(1'b0);
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: valid=%b addr=%h required 1 00000000", s_req_valid, s_req_addr);
        end
    endtask

    task automatic test_stream();
        int n0;
        do_reset(1'b0);
        lat_min = 1; lat_max = 1; rr_pct = 100;
        n0 = nrecv;
        repeat (30) step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (nrecv - n0 != 28) begin
            n_fail++;
            $display("FAIL stream_count: got %0d instructions required 28", nrecv - n0);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        logic [31:0] want;
        do_reset(1'b0);
        lat_min = 1; lat_max = 1; rr_pct = 100;
        repeat (10) step(1'b0, 1'b0, 32'h0);
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: out_valid=%b out_pc=%h req_valid=%b required 1 00000000 0", out_valid, out_pc, req_valid);
        end
        n0 = nrecv;
        repeat (6) step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (got_pc.size() < 4) begin
            n_fail++;
            $display("FAIL bp_release: got %0d instructions required at least 4", got_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                want = 32'(i * 4);
                n_checks++;
                if (got_pc[i] !== want) begin
                    n_fail++;
                    $display("FAIL bp_order: pc[%0d]=%h required %h", i, got_pc[i], want);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int k, n0;
        do_reset(1'b0);
        lat_min = 3; lat_max = 3; rr_pct = 100;
        k = 0;
        while (q.size() != 2 && k < 20) begin
            step(1'b1, 1'b0, 32'h0);
            k++;
        end
        n_checks++;
        if (k == 20) begin
            n_fail++;
            $display("FAIL redir_setup: inflight=%0d required 2 within 20 cycles", q.size());
        end
        step(1'b1, 1'b1, 32'h100);
        n0 = nrecv;
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_req: valid=%b addr=%h required 1 00000100", s_req_valid, s_req_addr);
        end
        k = 1;
        while (nrecv == n0 && k < 30) begin
            step(1'b1, 1'b0, 32'h0);
            k++;
        end
        n_checks++;
        if (k != 5 || got_pc.size() == 0 || got_pc[got_pc.size()-1] !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_first: latency=%0d last_pc=%h required 5 00000100", k,
                     got_pc.size() != 0 ? got_pc[got_pc.size()-1] : 32'hx);
        end
    endtask

    task automatic test_coincide();
        int k, n0;
        bit done;
        do_reset(1'b0);
        lat_min = 2; lat_max = 2; rr_pct = 100;
        repeat (6) step(1'b1, 1'b0, 32'h0);
        done = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            #1;
            if (q.size() != 0 && q[0].due == cyc && out_valid === 1'b1) begin
                n0 = nrecv;
                step(1'b1, 1'b1, 32'h103);
                done = 1'b1;
                n_checks++;
                if (nrecv != n0 + 1) begin
                    n_fail++;
                    $display("FAIL coincide_keep: handshakes=%0d required 1", nrecv - n0);
                end
            end else begin
                step(1'b1, 1'b0, 32'h0);
            end
            k++;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL coincide_setup: no response+handshake cycle within 20 cycles");
        end
        step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL align_req: valid=%b addr=%h required 1 00000100", s_req_valid, s_req_addr);
        end
        n0 = nrecv;
        repeat (10) step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (nrecv - n0 < 3) begin
            n_fail++;
            $display("FAIL coincide_resume: got %0d instructions required at least 3", nrecv - n0);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        do_reset(1'b1);
        lat_min = 1; lat_max = 1; rr_pct = 100;
        repeat (8) step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (got_pc.size() < 3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d instructions required at least 3", got_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_pc[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL wrap_pc: pc[%0d]=%h required %h", i, got_pc[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int n0;
        do_reset(1'b0);
        for (int p = 0; p < 4; p++) begin
            lat_min = 1;
            lat_max = $urandom_range(4, 1);
            rr_pct = $urandom_range(100, 40);
            repeat (150) step($urandom_range(99) < 70, $urandom_range(99) < 4, $urandom);
        end
        rr_pct = 100;
        n0 = nrecv;
        repeat (30) step(1'b1, 1'b0, 32'h0);
        n_checks++;
        if (nrecv - n0 < 10) begin
            n_fail++;
            $display("FAIL random_drain: got %0d instructions required at least 10", nrecv - n0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; nrecv = 0; cyc = 0;
        sel = 1'b0; rst = 1'b1;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_coincide();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
